// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing four 8-bit registers with a protected reg3
module i2c_target_regfile #(
  parameter logic [6:0]  I2C_ADDR = 7'h10,
  parameter logic [31:0] REG_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        arst_i,
  input  logic        domain,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oen,
  output logic [31:0] reg_out,
  output logic        wr_stb,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_t;

  state_t      r_state;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_rw;
  logic [1:0]  r_ptr;
  logic [31:0] r_regs;
  logic        r_sda_oen;
  logic        r_wr_stb;
  logic        r_busy;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
  logic [7:0] w_byte, w_rd_byte;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_last_bit = (r_bitcnt == 4'd7);
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  // Unprivileged requesters see reg3 as zero.
  assign w_rd_byte  = (r_ptr == 2'd3 && !domain) ? 8'h00 : r_regs[{r_ptr, 3'b000} +: 8];

  assign sda_o   = 1'b0;
  assign sda_oen = r_sda_oen;
  assign reg_out = r_regs;
  assign wr_stb  = r_wr_stb;
  assign busy    = r_busy;

  always_ff @(posedge clk or negedge arst_i) begin
    if (!arst_i) begin
      r_state   <= S_IDLE;
      r_scl_s1  <= 1'b1;
      r_scl_s2  <= 1'b1;
      r_scl_d   <= 1'b1;
      r_sda_s1  <= 1'b1;
      r_sda_s2  <= 1'b1;
      r_sda_d   <= 1'b1;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'h00;
      r_rw      <= 1'b0;
      r_ptr     <= 2'd0;
      r_regs    <= REG_RST;
      r_sda_oen <= 1'b1;
      r_wr_stb  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
      r_wr_stb <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bitcnt  <= 4'd0;
        r_sda_oen <= 1'b1;
        r_busy    <= 1'b1;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_oen <= 1'b1;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (w_last_bit) begin
                r_bitcnt <= 4'd0;
                case (r_state)
                  S_ADDR: begin
                    if (w_byte[7:1] == I2C_ADDR) begin
                      r_rw    <= w_byte[0];
                      r_state <= S_ADDR_ACK;
                    end else begin
                      r_state <= S_WAIT_STOP;
                      r_busy  <= 1'b0;
                    end
                  end
                  S_PTR: begin
                    r_ptr   <= w_byte[1:0];
                    r_state <= S_PTR_ACK;
                  end
                  default: begin
                    if (r_ptr != 2'd3 || domain) begin
                      r_regs[{r_ptr, 3'b000} +: 8] <= w_byte;
                      r_wr_stb <= 1'b1;
                    end
                    r_ptr   <= r_ptr + 2'd1;
                    r_state <= S_WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // bitcnt 0: first fall starts ACK; 1: fall after the ACK clock ends it.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_rise) begin
              r_bitcnt <= 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd0) begin
                r_sda_oen <= 1'b0;
              end else begin
                r_bitcnt  <= 4'd0;
                r_sda_oen <= 1'b1;
                if (r_state == S_ADDR_ACK && r_rw) begin
                  r_state   <= S_RDATA;
                  r_shift   <= w_rd_byte;
                  r_sda_oen <= w_rd_byte[7];
                end else if (r_state == S_ADDR_ACK) begin
                  r_state <= S_PTR;
                end else begin
                  r_state <= S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_oen <= 1'b1;
                r_bitcnt  <= 4'd0;
                r_state   <= S_RDATA_ACK;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_oen <= r_shift[6];
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (r_sda_s2) begin
                r_state <= S_WAIT_STOP;
                r_busy  <= 1'b0;
              end else begin
                r_ptr <= r_ptr + 2'd1;
              end
            end else if (w_scl_fall) begin
              r_state   <= S_RDATA;
              r_shift   <= w_rd_byte;
              r_sda_oen <= w_rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 Parameter I2C_ADDR, default 7'h10, 7-bit target address matched against the address byte.
REQ-002 Parameter REG_RST, default 32'h0, reset contents of reg0..reg3 (reg n = bits 8n+7:8n).
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 arst_i  input  1  asynchronous, active-low reset.
REQ-005 domain  input  1  requester security level; 1 = privileged.
REQ-006 scl_i  input  1  I2C clock pad value (target never drives SCL).
REQ-007 sda_i  input  1  I2C data pad value.
REQ-008 sda_o  output  1  constant 1'b0 (open-drain data).
REQ-009 sda_oen  output  1  1 = release SDA, 0 = pull low.
REQ-010 reg_out  output  32  current contents of reg3..reg0.
REQ-011 wr_stb  output  1  one-cycle pulse when a register is written.
REQ-012 busy  output  1  high from START to STOP or NACK-abort.

Function
REQ-013 scl_i and sda_i shall pass through a 2-flop synchronizer; all edge detection uses the synchronized values.
REQ-014 START = synced SDA falls while synced SCL high; STOP = synced SDA rises while synced SCL high.
REQ-015 Bits shall be sampled on synced SCL rising edge; target-driven SDA changes only on synced SCL falling edge.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-017 START in any state -> ADDR, bit counter cleared, SDA released (repeated START supported).
REQ-018 STOP in any state -> IDLE, SDA released, busy low on the following cycle.
REQ-019 ADDR: shift 8 bits MSB-first; on 8th bit, addr[7:1]==I2C_ADDR -> ADDR_ACK, else WAIT_STOP with SDA released (NACK).
REQ-020 ACK drive: sda_oen=0 from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.
REQ-021 ADDR_ACK with R/W=0 -> PTR; with R/W=1 -> RDATA, loading shift register from reg[ptr] at the ACK-ending SCL fall and driving MSB there.
REQ-022 PTR: 8-bit byte received; ptr <= byte[1:0], upper 6 bits ignored; always ACKed; then WDATA.
REQ-023 WDATA: 8-bit byte, ACKed, written to reg[ptr] on the 8th SCL rise; wr_stb pulses that cycle; ptr increments mod 4 (3 -> 0).
REQ-024 Protected reg3: when domain==0, writes to reg3 are dropped (still ACKed, no wr_stb, ptr still increments) and reads of reg3 return 8'h00.
REQ-025 RDATA: sda_oen = current shift bit (1 = release) per bit; after bit 8 release SDA for master ACK bit.
REQ-026 RDATA_ACK: sample SDA on 9th SCL rise; 0 -> ptr increments mod 4, next byte loaded, RDATA; 1 -> WAIT_STOP, SDA released.
REQ-027 WAIT_STOP ignores all bits and exits only on START or STOP.
REQ-028 ptr persists across transactions; cleared only by reset.
REQ-029 domain is sampled at the read-load or write-commit cycle.
REQ-030 No clock stretching; target shall never drive SDA in IDLE or WAIT_STOP.

Reset
REQ-031 arst_i low: state IDLE, ptr 0, regs = REG_RST, sda_oen 1, sda_o 0, wr_stb 0, busy 0, synchronizers 1; effective immediately, no clock required.
REQ-032 Reset mid-transfer abandons transfer; after release the target waits for a new START.

Verification
REQ-033 domain=1, write 0x20,0x01,0xA5,0x5A (addr 0x10 W) -> 4 ACKs, reg1=0xA5, reg2=0x5A, wr_stb twice, ptr=3.
REQ-034 Address 0x11 W -> NACK at bit 9, no further SDA drive, busy low after STOP.
REQ-035 After REQ-033, write ptr 0x01, repeated START, read 0x21, master ACK,ACK,ACK,NACK -> bytes 0xA5,0x5A,reg3,reg0 (wrap).
REQ-036 domain=0: write ptr 3, data 0xFF -> ACKed, reg3 unchanged, no wr_stb; read reg3 -> 0x00; domain=1 read -> real reg3.
REQ-037 Pull arst_i low during RDATA bit 4 -> sda_oen=1 same cycle, regs = REG_RST; next full transaction succeeds.
REQ-038 STOP issued after bit 3 of WDATA -> IDLE, no register write, no wr_stb.
